// File: rtl/fir_stream_driver.sv
// Drives a one-sample-in-flight FIR from a valid/ready stream and returns its results as a framed stream.
// Build option FIR_DRV_TIMEOUT_EN adds a WAIT_OUT watchdog that sets timeout_err.
module fir_stream_driver #(
  parameter int IN_W           = 16,
  parameter int OUT_W          = 38,
  parameter int FRAME_LEN      = 221184,
  parameter int CNT_W          = 18,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [IN_W-1:0]  s_data,
  output logic             s_ready,
  output logic             fir_in_valid,
  output logic [IN_W-1:0]  fir_in,
  input  logic             fir_out_valid,
  input  logic [OUT_W-1:0] fir_out,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             spurious_err,
  output logic             timeout_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  if ((64'd1 << CNT_W) < 64'(FRAME_LEN)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for FRAME_LEN");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic [IN_W-1:0]  fir_in_q, fir_in_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             spur_q, spur_d;
  logic             tmo_hit;

  logic is_idle, is_issue, is_wait, is_hold;

  assign is_idle  = (state_q == ST_IDLE);
  assign is_issue = (state_q == ST_ISSUE);
  assign is_wait  = (state_q == ST_WAIT);
  assign is_hold  = (state_q == ST_HOLD);

`ifdef FIR_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmo_q, tmo_d;

  always_comb begin
    tmr_d = tmr_q;
    tmo_d = tmo_q | tmo_hit;
    if (is_issue) begin
      tmr_d = '0;
    end else if (is_wait) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  assign tmo_hit = is_wait && !fir_out_valid && (tmr_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    fir_in_d = fir_in_q;
    m_data_d = m_data_q;
    m_last_d = m_last_q;
    cnt_d    = cnt_q;
    // A strobe is only legal while a sample is outstanding.
    spur_d   = spur_q | (fir_out_valid && !is_wait);
    unique case (1'b1)
      is_idle: begin
        if (s_valid) begin
          fir_in_d = s_data;
          state_d  = ST_ISSUE;
        end
      end
      is_issue: begin
        state_d = ST_WAIT;
      end
      is_wait: begin
        if (fir_out_valid) begin
          m_data_d = fir_out;
          m_last_d = (cnt_q == LAST_IDX);
          state_d  = ST_HOLD;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      is_hold: begin
        if (m_ready) begin
          cnt_d    = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
          m_last_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      fir_in_q <= '0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
      cnt_q    <= '0;
      spur_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fir_in_q <= fir_in_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
      cnt_q    <= cnt_d;
      spur_q   <= spur_d;
    end
  end

  assign s_ready      = is_idle;
  assign busy         = !is_idle;
  assign fir_in_valid = is_issue;
  assign fir_in       = fir_in_q;
  assign m_valid      = is_hold;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign frame_cnt    = cnt_q;
  assign spurious_err = spur_q;

endmodule
